// File: rtl/cpu_mem_pkg.sv
// cpu_mem_pkg: shared state encoding and byte-order helpers for the program memory
package cpu_mem_pkg;
   typedef enum logic [1:0] {ST_EMPTY, ST_LOAD, ST_RUN} pm_state_e;
   localparam bit ORDER_LE = 1'b0;
   localparam bit ORDER_BE = 1'b1;
   // Fetch-word lane (0 = least significant byte) that carries the byte at addr+i.
   function automatic int byte_lane(input int i, input int fetch_bytes, input bit big_endian);
      return (big_endian == ORDER_BE) ? fetch_bytes - 1 - i : i;
   endfunction
endpackage

// File: rtl/pmem_byte_ram.sv
// pmem_byte_ram: byte-wide write port, FETCH_BYTES-wide combinational read of consecutive bytes
//   clk   : write clock
//   we    : write enable for wdata at waddr
//   raddr : first byte of the read window; rdata byte i = mem[raddr+i] (address wraps)
module pmem_byte_ram #(
   parameter int DEPTH       = 256,
   parameter int FETCH_BYTES = 4
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [$clog2(DEPTH)-1:0]     waddr,
   input  logic [7:0]                   wdata,
   input  logic [$clog2(DEPTH)-1:0]     raddr,
   output logic [8*FETCH_BYTES-1:0]     rdata
);
   localparam int AW = $clog2(DEPTH);
   logic [7:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   for (genvar i = 0; i < FETCH_BYTES; i++) begin : g_rd
      assign rdata[8*i +: 8] = mem[raddr + AW'(i)];
   end
endmodule

// File: rtl/program_memory_loadable.sv
// program_memory_loadable: byte-streamed program image store with a one-cycle fetch port
//   load_start             : restart image load at address 0
//   ld_valid/ld_ready      : image byte handshake (ld_data, ld_last marks final byte)
//   ld_ovf                 : sticky, image filled DEPTH without ld_last
//   fe_valid/fe_ready      : fetch request at byte address fe_addr
//   rsp_valid/rsp_ready    : fetch response rsp_data / rsp_err
//   img_len                : bytes in the loaded image
module program_memory_loadable
   import cpu_mem_pkg::*;
#(
   parameter int DEPTH       = 256,
   parameter int FETCH_BYTES = 4,
   parameter bit BIG_ENDIAN  = 1'b1,
   parameter bit ALIGN_CHECK = 1'b0
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       load_start,
   input  logic                       ld_valid,
   output logic                       ld_ready,
   input  logic [7:0]                 ld_data,
   input  logic                       ld_last,
   output logic                       ld_ovf,
   input  logic                       fe_valid,
   output logic                       fe_ready,
   input  logic [31:0]                fe_addr,
   output logic                       rsp_valid,
   input  logic                       rsp_ready,
   output logic [8*FETCH_BYTES-1:0]   rsp_data,
   output logic                       rsp_err,
   output logic [$clog2(DEPTH):0]     img_len
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int DW = 8 * FETCH_BYTES;
   pm_state_e     state, state_nx;
   logic [AW-1:0] ptr;
   logic [DW-1:0] ram_rdata, word;
   logic          ld_acc, ld_done, fe_acc, fe_err;
   assign ld_ready = state == ST_LOAD;
   // load_start takes priority over a byte offered in the same cycle
   assign ld_acc   = ld_valid && ld_ready && !load_start;
   assign ld_done  = ld_acc && (ld_last || ptr == AW'(DEPTH - 1));
   assign fe_ready = state != ST_LOAD && (!rsp_valid || rsp_ready);
   assign fe_acc   = fe_valid && fe_ready;
   // range check at 33 bits so addresses near 2^32 cannot wrap into range
   assign fe_err   = state == ST_EMPTY
                  || ({1'b0, fe_addr} + 33'(FETCH_BYTES) > 33'(img_len))
                  || (ALIGN_CHECK && (fe_addr & 32'(FETCH_BYTES - 1)) != 32'd0);
   always_comb state_nx = load_start ? ST_LOAD : ld_done ? ST_RUN : state;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) state <= ST_EMPTY;
      else          state <= state_nx;
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         ptr     <= '0;
         img_len <= '0;
         ld_ovf  <= 1'b0;
      end else if (load_start) begin
         ptr     <= '0;
         img_len <= '0;
         ld_ovf  <= 1'b0;
      end else if (ld_acc) begin
         ptr <= ptr + 1'b1;
         if (ld_done) img_len <= LW'(ptr) + LW'(1);
         if (ld_done && !ld_last) ld_ovf <= 1'b1;
      end
   pmem_byte_ram #(.DEPTH(DEPTH), .FETCH_BYTES(FETCH_BYTES)) u_ram (
      .clk   (clk),
      .we    (ld_acc),
      .waddr (ptr),
      .wdata (ld_data),
      .raddr (fe_addr[AW-1:0]),
      .rdata (ram_rdata)
   );
   for (genvar i = 0; i < FETCH_BYTES; i++) begin : g_lane
      assign word[8*byte_lane(i, FETCH_BYTES, BIG_ENDIAN) +: 8] = ram_rdata[8*i +: 8];
   end
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         rsp_valid <= 1'b0;
         rsp_err   <= 1'b0;
         rsp_data  <= '0;
      end else if (fe_acc) begin
         rsp_valid <= 1'b1;
         rsp_err   <= fe_err;
         rsp_data  <= fe_err ? '0 : word;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
endmodule
